// File: rtl/conv_output_streamer_pkg.sv
// Shared types and helpers for conv_output_streamer: FSM state, tensor sizing,
// and Q_WIDTH saturation limits.
package conv_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_e;

    localparam int unsigned QWidthDefault = 16;

    // Never returns 0 so that counters for single-element shapes stay legal.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((longint'(1) << r) < longint'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned num_elems(input int unsigned b, input int unsigned c,
                                              input int unsigned h, input int unsigned w);
        return b * c * h * w;
    endfunction

    function automatic longint sat_max(input int unsigned qw);
        return (longint'(1) << (qw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned qw);
        return -(longint'(1) << (qw - 1));
    endfunction

    localparam longint QMaxDefault = sat_max(QWidthDefault);
    localparam longint QMinDefault = sat_min(QWidthDefault);

endpackage

// File: rtl/conv_output_streamer_if.sv
// Valid/ready output stream of conv_output_streamer, with channel and tensor end flags.
interface conv_output_streamer_if #(
    parameter int unsigned Q_WIDTH = 16
);
    logic               m_valid;
    logic               m_ready;
    logic [Q_WIDTH-1:0] m_data;
    logic               m_eoc;
    logic               m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_eoc,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_eoc,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/conv_output_streamer_requant_sat.sv
// Combinational requantizer: optional ReLU, half-up round, arithmetic shift, saturate.
// ReLU is enabled by defining CONV_STREAM_RELU_EN.
module requant_sat
    import conv_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned Q_WIDTH    = 16,
    parameter int unsigned SHIFT      = 8
) (
    input  logic [DATA_WIDTH-1:0] i_x,
    output logic [Q_WIDTH-1:0]    o_q
);
    localparam int unsigned RoundIdx = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [DATA_WIDTH:0] RoundTerm =
        (SHIFT == 0) ? '0 : ((DATA_WIDTH + 1)'(1) << RoundIdx);
    localparam logic signed [DATA_WIDTH:0] SatHi = (DATA_WIDTH + 1)'(sat_max(Q_WIDTH));
    localparam logic signed [DATA_WIDTH:0] SatLo = (DATA_WIDTH + 1)'(sat_min(Q_WIDTH));

    logic [DATA_WIDTH-1:0]        w_x;
    logic signed [DATA_WIDTH:0]   w_sum;
    logic signed [DATA_WIDTH:0]   w_t;

    always_comb begin
`ifdef CONV_STREAM_RELU_EN
        w_x = i_x[DATA_WIDTH-1] ? '0 : i_x;
`else
        w_x = i_x;
`endif
        // One extra bit of headroom keeps the rounding add from wrapping.
        w_sum = $signed({w_x[DATA_WIDTH-1], w_x}) + RoundTerm;
        w_t   = w_sum >>> SHIFT;
        if (w_t > SatHi) begin
            o_q = SatHi[Q_WIDTH-1:0];
        end else if (w_t < SatLo) begin
            o_q = SatLo[Q_WIDTH-1:0];
        end else begin
            o_q = w_t[Q_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/conv_output_streamer.sv
// Snapshots a conv2d output tensor on start and streams it, requantized, one element per
// handshake. Build option: CONV_STREAM_RELU_EN (clamps negative inputs to zero).
module conv_output_streamer
    import conv_stream_pkg::*;
#(
    parameter int unsigned BATCH_SIZE = 1,
    parameter int unsigned CHANNELS   = 32,
    parameter int unsigned HEIGHT     = 7,
    parameter int unsigned WIDTH      = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned Q_WIDTH    = 16,
    parameter int unsigned SHIFT      = 8
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic                                              i_start,
    input  logic [BATCH_SIZE*CHANNELS*HEIGHT*WIDTH*DATA_WIDTH-1:0] i_tensor_flat,
    output logic                                              o_busy,
    output logic                                              o_done,
    conv_output_streamer_if.master                            m_if
);
    localparam int unsigned N    = num_elems(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH);
    localparam int unsigned HW   = HEIGHT * WIDTH;
    localparam int unsigned IdxW = clog2(N);
    localparam int unsigned PixW = clog2(HW);

    state_e r_state, w_state_next;

    logic [DATA_WIDTH-1:0] r_snap [N];
    logic [IdxW-1:0]       r_idx, w_idx_next;
    logic [PixW-1:0]       r_pix, w_pix_next;
    logic                  r_valid, w_valid_next;
    logic [Q_WIDTH-1:0]    r_data, w_data_next;
    logic                  r_eoc, w_eoc_next;
    logic                  r_last, w_last_next;

    logic                  w_accept, w_at_last;
    logic                  w_load, w_adv, w_end;
    logic [DATA_WIDTH-1:0] w_x;
    logic [Q_WIDTH-1:0]    w_q;

    assign w_accept  = r_valid && m_if.m_ready;
    assign w_at_last = (r_idx == IdxW'(N - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_next = StStream;
            StStream: if (w_accept && w_at_last) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_load       = (r_state == StIdle) && i_start;
        w_adv        = (r_state == StStream) && w_accept && !w_at_last;
        w_end        = (r_state == StStream) && w_accept && w_at_last;
        w_idx_next   = r_idx;
        w_pix_next   = r_pix;
        w_valid_next = r_valid;
        w_data_next  = r_data;
        w_eoc_next   = r_eoc;
        w_last_next  = r_last;
        if (w_load) begin
            w_idx_next = '0;
            w_pix_next = '0;
        end else if (w_adv) begin
            w_idx_next = r_idx + 1'b1;
            w_pix_next = (r_pix == PixW'(HW - 1)) ? '0 : r_pix + 1'b1;
        end else if (w_end) begin
            w_idx_next = '0;
            w_pix_next = '0;
        end
        if (w_load || w_adv) begin
            w_valid_next = 1'b1;
            w_data_next  = w_q;
            w_eoc_next   = (w_pix_next == PixW'(HW - 1));
            w_last_next  = (w_idx_next == IdxW'(N - 1));
        end else if (w_end) begin
            w_valid_next = 1'b0;
            w_data_next  = '0;
            w_eoc_next   = 1'b0;
            w_last_next  = 1'b0;
        end
    end

    // Element 0 must be presented on the capture edge, before the snapshot holds it.
    assign w_x = w_load ? i_tensor_flat[DATA_WIDTH-1:0] : r_snap[w_idx_next];

    requant_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q_WIDTH    (Q_WIDTH),
        .SHIFT      (SHIFT)
    ) u_requant (
        .i_x (w_x),
        .o_q (w_q)
    );

    always_ff @(posedge i_clk) begin
        if (w_load) begin
            for (int e = 0; e < int'(N); e++) begin
                r_snap[e] <= i_tensor_flat[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_idx   <= '0;
            r_pix   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_eoc   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_idx   <= w_idx_next;
            r_pix   <= w_pix_next;
            r_valid <= w_valid_next;
            r_data  <= w_data_next;
            r_eoc   <= w_eoc_next;
            r_last  <= w_last_next;
        end
    end

    assign o_busy         = (r_state != StIdle);
    assign o_done         = (r_state == StDone);
    assign m_if.m_valid   = r_valid;
    assign m_if.m_data    = r_data;
    assign m_if.m_eoc     = r_eoc;
    assign m_if.m_last    = r_last;
endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed self-checking bench for conv_output_streamer (default 1x32x7x7, SHIFT=8).
module tb_conv_output_streamer;
    localparam int N  = 1568;
    localparam int HW = 49;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [N*DW-1:0] tensor;
    logic            busy;
    logic            done;

    int n_vec;
    int n_err;

    conv_output_streamer_if #(.Q_WIDTH(16)) s_if ();

    conv_output_streamer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_tensor_flat (tensor),
        .o_busy        (busy),
        .o_done        (done),
        .m_if          (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int ofs);
        for (int i = 0; i < N; i++) tensor[i*DW +: DW] = (i + ofs) << 8;
    endtask

    task automatic wait_idle(output bit timed_out);
        int c;
        c = 0;
        while (busy && c < N + 100) begin
            step();
            c++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        s_if.m_ready = 1'b0;
        tensor = '0;
        step();
        step();
        n_vec++;
        if ({busy, done, s_if.m_valid, s_if.m_data, s_if.m_eoc, s_if.m_last} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b data=%h eoc=%b last=%b want all 0",
                     busy, done, s_if.m_valid, s_if.m_data, s_if.m_eoc, s_if.m_last);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_order();
        fill_ramp(0);
        s_if.m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (s_if.m_valid !== 1'b1 || s_if.m_data !== 16'(i) || busy !== 1'b1 ||
                done !== 1'b0 || s_if.m_eoc !== ((i + 1) % HW == 0) ||
                s_if.m_last !== (i == N - 1)) begin
                n_err++;
                $display("FAIL order[%0d]: got v=%b d=%0d eoc=%b last=%b busy=%b done=%b want v=1 d=%0d eoc=%b last=%b busy=1 done=0",
                         i, s_if.m_valid, s_if.m_data, s_if.m_eoc, s_if.m_last, busy, done,
                         i, ((i + 1) % HW == 0), (i == N - 1));
            end
            step();
        end
        n_vec++;
        if (s_if.m_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: got v=%b done=%b busy=%b want v=0 done=1 busy=1",
                     s_if.m_valid, done, busy);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_end: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] xin [7];
        logic [15:0] want [7];
        bit          to;
        xin[0] = 32'h0000_0180; want[0] = 16'h0002;
        xin[1] = 32'h0000_017F; want[1] = 16'h0001;
        xin[3] = 32'h7FFF_FFFF; want[3] = 16'h7FFF;
        xin[5] = 32'hFFFF_FF80; want[5] = 16'h0000;
        xin[6] = 32'h0000_0000; want[6] = 16'h0000;
`ifdef CONV_STREAM_RELU_EN
        xin[2] = 32'hFFFF_FE80; want[2] = 16'h0000;
        xin[4] = 32'h8000_0000; want[4] = 16'h0000;
`else
        xin[2] = 32'hFFFF_FE80; want[2] = 16'hFFFF;
        xin[4] = 32'h8000_0000; want[4] = 16'h8000;
`endif
        tensor = '0;
        for (int i = 0; i < 7; i++) tensor[i*DW +: DW] = xin[i];
        s_if.m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (s_if.m_valid !== 1'b1 || s_if.m_data !== want[i]) begin
                n_err++;
                $display("FAIL requant[x=%h]: got v=%b d=%h want v=1 d=%h",
                         xin[i], s_if.m_valid, s_if.m_data, want[i]);
            end
            step();
        end
        wait_idle(to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL rounding_drain: got busy=%b want 0 within bound", busy);
        end
    endtask

    task automatic test_backpressure();
        int          k;
        int          cycles;
        bit          prev_stall;
        bit          fire;
        logic [15:0] p_data;
        logic        p_eoc;
        logic        p_last;
        fill_ramp(0);
        s_if.m_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        cycles = 0;
        prev_stall = 1'b0;
        p_data = '0;
        p_eoc = 1'b0;
        p_last = 1'b0;
        while (k < N && cycles < 20000) begin
            if (prev_stall) begin
                n_vec++;
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== p_data ||
                    s_if.m_eoc !== p_eoc || s_if.m_last !== p_last) begin
                    n_err++;
                    $display("FAIL stall_hold[%0d]: got v=%b d=%h eoc=%b last=%b want v=1 d=%h eoc=%b last=%b",
                             k, s_if.m_valid, s_if.m_data, s_if.m_eoc, s_if.m_last,
                             p_data, p_eoc, p_last);
                end
            end
            if (s_if.m_valid === 1'b1) begin
                n_vec++;
                if (s_if.m_data !== 16'(k) || s_if.m_eoc !== ((k + 1) % HW == 0) ||
                    s_if.m_last !== (k == N - 1)) begin
                    n_err++;
                    $display("FAIL bp_elem[%0d]: got d=%0d eoc=%b last=%b want d=%0d eoc=%b last=%b",
                             k, s_if.m_data, s_if.m_eoc, s_if.m_last, k,
                             ((k + 1) % HW == 0), (k == N - 1));
                end
            end
            s_if.m_ready = ($urandom_range(0, 9) < 3);
            fire = (s_if.m_valid === 1'b1) && s_if.m_ready;
            prev_stall = (s_if.m_valid === 1'b1) && !s_if.m_ready;
            p_data = s_if.m_data;
            p_eoc = s_if.m_eoc;
            p_last = s_if.m_last;
            step();
            if (fire) k++;
            cycles++;
        end
        n_vec++;
        if (k != N) begin
            n_err++;
            $display("FAIL bp_count: got %0d elements want %0d", k, N);
        end
        n_vec++;
        if (done !== 1'b1 || s_if.m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_done: got done=%b v=%b want done=1 v=0", done, s_if.m_valid);
        end
        s_if.m_ready = 1'b1;
        step();
    endtask

    task automatic test_snapshot_restart();
        bit to;
        fill_ramp(0);
        s_if.m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (s_if.m_valid !== 1'b1 || s_if.m_data !== 16'(i)) begin
                n_err++;
                $display("FAIL snapshot[%0d]: got v=%b d=%0d want v=1 d=%0d",
                         i, s_if.m_valid, s_if.m_data, i);
            end
            if (i == 50) begin
                for (int e = 0; e < N; e++) tensor[e*DW +: DW] = 32'h7FFF_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        // Now in the done cycle: a start here must be dropped.
        fill_ramp(3);
        start = 1'b1;
        step();
        n_vec++;
        if (s_if.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: got v=%b busy=%b done=%b want 0 0 0",
                     s_if.m_valid, busy, done);
        end
        step();
        start = 1'b0;
        n_vec++;
        if (s_if.m_valid !== 1'b1 || busy !== 1'b1 || s_if.m_data !== 16'd3) begin
            n_err++;
            $display("FAIL restart: got v=%b busy=%b d=%0d want v=1 busy=1 d=3",
                     s_if.m_valid, busy, s_if.m_data);
        end
        wait_idle(to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL restart_drain: got busy=%b want 0 within bound", busy);
        end
    endtask

    task automatic test_reset_midstream();
        fill_ramp(0);
        s_if.m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 500; i++) step();
        n_vec++;
        if (s_if.m_data !== 16'd500) begin
            n_err++;
            $display("FAIL pre_reset: got d=%0d want 500", s_if.m_data);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_vec++;
        if ({busy, done, s_if.m_valid, s_if.m_data, s_if.m_eoc, s_if.m_last} !== 20'h0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b done=%b v=%b d=%h eoc=%b last=%b want all 0",
                     busy, done, s_if.m_valid, s_if.m_data, s_if.m_eoc, s_if.m_last);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || s_if.m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_done_after_reset: got done=%b v=%b want 0 0", done, s_if.m_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (s_if.m_valid !== 1'b1 || s_if.m_data !== 16'(i)) begin
                n_err++;
                $display("FAIL post_reset[%0d]: got v=%b d=%0d want v=1 d=%0d",
                         i, s_if.m_valid, s_if.m_data, i);
            end
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_order();
        test_rounding();
        test_backpressure();
        test_snapshot_restart();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_output_streamer.md
# conv_output_streamer

Downstream stage of `conv2d`: snapshots the flat output tensor on a `start` pulse, then emits it one element per handshake on a valid/ready stream. Each element is rounded, right-shifted and saturated from DATA_WIDTH to Q_WIDTH, with optional ReLU. Element order is the flat tensor order: batch, channel, row, column. The stream feeds the entropy-model and quantizer path, so `conv2d` is free to start the next layer as soon as the snapshot is taken.

## Interface
- BATCH_SIZE, 1, batches in the tensor
- CHANNELS, 32, feature channels (the conv OUT_CHANNELS)
- HEIGHT, 7, rows per channel
- WIDTH, 7, columns per row
- DATA_WIDTH, 32, input element width, signed two's complement
- Q_WIDTH, 16, output element width, signed
- SHIFT, 8, arithmetic right shift applied during requantization (0..DATA_WIDTH-1)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to capture `tensor_flat` and stream it
- tensor_flat  in  BATCH_SIZE*CHANNELS*HEIGHT*WIDTH*DATA_WIDTH  flat tensor; element i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high from capture until `done` completes
- m_valid  out  1  output element valid
- m_ready  in  1  downstream accepts the element
- m_data  out  Q_WIDTH  requantized element
- m_eoc  out  1  marks the final element of a channel (w=WIDTH-1, h=HEIGHT-1)
- m_last  out  1  marks the final element of the tensor
- done  out  1  one-cycle pulse after the last handshake

## Operation
- N = BATCH_SIZE*CHANNELS*HEIGHT*WIDTH. Default N is 1568. Index counter width is clog2(N).
- States:
  - IDLE -> STREAM on `start` (capture). STREAM -> DONE on the handshake of element N-1. DONE -> IDLE unconditionally.
  - `start` is ignored in STREAM and DONE. No queueing.
- Capture: the whole `tensor_flat` is registered into the snapshot buffer in the same cycle as the IDLE-to-STREAM transition. Later changes on `tensor_flat` have no effect.
- Handshake: a transfer occurs when `m_valid && m_ready` on a clock edge.
  - While `m_valid` is high and `m_ready` is low, `m_data`, `m_eoc` and `m_last` hold stable.
  - `m_valid` never drops before a transfer.
- Requantization of element x (signed DATA_WIDTH):
  - Compute t = (x + 2^(SHIFT-1)) >>> SHIFT at DATA_WIDTH+1 bits, so rounding is half-up and the addition cannot overflow. When SHIFT=0 the rounding term is 0.
  - Saturate t to [-2^(Q_WIDTH-1), 2^(Q_WIDTH-1)-1].
- `m_eoc` is high for elements where (i+1) mod (HEIGHT*WIDTH) == 0. `m_last` is high only for i = N-1. Element N-1 carries both.
- Reset, including mid-stream: state goes to IDLE, the counter clears, and the stream is aborted. No `done` is produced.

## Timing
- Reset values: busy=0, m_valid=0, m_data=0, m_eoc=0, m_last=0, done=0.
- `start` sampled at edge k: `busy` and `m_valid` are high after edge k, presenting element 0.
- Output is registered. Element i+1 is presented the cycle after the handshake of element i, so throughput is 1 element/cycle when `m_ready` stays high.
- Handshake of element N-1 at edge j:
  - After edge j: `m_valid`=0 and `done`=1, with `busy` still 1.
  - After edge j+1: `done`=0 and `busy`=0. The next `start` is accepted at edge j+2 or later.
- Minimum latency from `start` to `done` is N+1 cycles.

## Configuration
- `CONV_STREAM_RELU_EN` defined: negative x maps to 0 before requantization, so `m_data` is never negative.
- `CONV_STREAM_RELU_EN` undefined: signed pass-through into requantization.

## Structure
- Package `conv_stream_pkg` holds:
  - the state enum (IDLE, STREAM, DONE)
  - a `num_elems` function computing N
  - a `clog2` helper
  - Q_WIDTH saturation limit constants
- Sub-module `requant_sat`: purely combinational round, shift, saturate and optional ReLU on a single element. The top module owns the FSM, counter, snapshot and output register.

## Test plan
- Element order and flags: tensor where element i = i<<8, `m_ready` held at 1.
  - `m_data` = i for all 1568 elements, in 1568 consecutive cycles.
  - `m_eoc` is seen at i=48, 97, …, 1567; `m_last` only at 1567.
  - `done` fires 1 cycle after element 1567.
- Rounding: x=0x00000180 gives 0x0002; x=0x0000017F gives 0x0001; x=0xFFFFFE80 gives 0xFFFF.
  - With `CONV_STREAM_RELU_EN` defined, x=0xFFFFFE80 gives 0x0000.
- Saturation: x=0x7FFFFFFF gives 0x7FFF; x=0x80000000 gives 0x8000 (macro undefined).
- Backpressure: random `m_ready` at 30% duty.
  - Outputs are stable during every stall.
  - No element is lost or duplicated; the sequence matches the ready-always-high run.
- Snapshot and restart:
  - Change `tensor_flat` and pulse `start` mid-stream: the stream is unaffected.
  - `start` in the `done` cycle is ignored; `start` 2 cycles after the last handshake begins a new stream.
- Reset mid-stream: assert `rst`=0 at element 500.
  - Next cycle: all outputs 0 and no `done`.
  - A following `start` streams from element 0.
